// File: rtl/pit_irq_collector.sv
// rtl/pit_irq_collector.sv - timer event counter with threshold/mask coalesced level irq; optional PIT_IRQ_TIMESTAMP_EN
module pit_irq_collector #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             mask_wr,
    input  logic             mask_val,
    input  logic             thresh_wr,
    input  logic [CNT_W-1:0] thresh_val,
    input  logic             ack,
    output logic             irq,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overrun,
    output logic [TS_W-1:0]  ts_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
        S_ASSERT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W-1:0] thresh, thresh_nx, eff_thresh;
    logic             mask, mask_nx;
    logic             ovr, ovr_nx;
    logic             first_evt;

    // Next-state: register writes, counter priority, then irq qualification on the new values
    always_comb begin
        mask_nx    = mask_wr ? mask_val : mask;
        thresh_nx  = thresh_wr ? thresh_val : thresh;
        eff_thresh = (thresh_nx == '0) ? CNT_ONE : thresh_nx;
        count_nx   = count;
        ovr_nx     = ovr;
        first_evt  = 1'b0;
        if (ack && tick_in) begin
            // ack retires everything pending; the tick becomes the first new event
            count_nx  = CNT_ONE;
            ovr_nx    = 1'b0;
            first_evt = 1'b1;
        end else if (ack) begin
            count_nx = '0;
            ovr_nx   = 1'b0;
        end else if (tick_in && count == CNT_MAX) begin
            ovr_nx = 1'b1;
        end else if (tick_in) begin
            count_nx  = count + CNT_ONE;
            first_evt = (count == '0);
        end
        if (count_nx == '0)
            state_nx = S_IDLE;
        else if (!mask_nx && count_nx >= eff_thresh)
            state_nx = S_ASSERT;
        else
            state_nx = S_PENDING;
    end

    // State, counter and configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            ovr    <= 1'b0;
            mask   <= 1'b1;
            thresh <= CNT_ONE;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            ovr    <= ovr_nx;
            mask   <= mask_nx;
            thresh <= thresh_nx;
        end
    end

    assign irq         = (state == S_ASSERT);
    assign pending_cnt = count;
    assign overrun     = ovr;

`ifdef PIT_IRQ_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q;

    // Free-running timebase; capture it when the first event after an ack is counted
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (first_evt)
                ts_q <= ts_cnt;
        end
    end

    assign ts_out = ts_q;
`else
    logic unused_first_evt;
    assign unused_first_evt = first_evt;
    assign ts_out           = '0;
`endif

endmodule

// File: tb/tb_pit_irq_collector.sv
// tb/tb_pit_irq_collector.sv - scoreboard bench for pit_irq_collector
module tb_pit_irq_collector;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in, mask_wr, mask_val, thresh_wr, ack;
    logic [7:0] thresh_val;
    logic       irq, overrun;
    logic [7:0] pending_cnt;
    logic [15:0] ts_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cnt;
        logic        irq;
        logic        ovr;
        logic [15:0] ts;
    } exp_t;
    exp_t sb[$];

    // reference state
    int   m_cnt, m_thr, m_tsc, m_ts;
    logic m_mask, m_ovr, m_irq;

    pit_irq_collector #(.CNT_W(8), .TS_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .mask_wr    (mask_wr),
        .mask_val   (mask_val),
        .thresh_wr  (thresh_wr),
        .thresh_val (thresh_val),
        .ack        (ack),
        .irq        (irq),
        .pending_cnt(pending_cnt),
        .overrun    (overrun),
        .ts_out     (ts_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic r, t, a, mw, mv, tw, input int tv);
        exp_t e;
        if (r) begin
            m_cnt = 0; m_ovr = 0; m_mask = 1; m_thr = 1; m_tsc = 0; m_ts = 0; m_irq = 0;
        end else begin
            if (mw) m_mask = mv;
            if (tw) m_thr = tv;
            if (a) begin
                m_ovr = 0;
                if (t) begin m_cnt = 1; m_ts = m_tsc; end
                else m_cnt = 0;
            end else if (t) begin
                if (m_cnt == 255) m_ovr = 1;
                else begin
                    if (m_cnt == 0) m_ts = m_tsc;
                    m_cnt = m_cnt + 1;
                end
            end
            m_irq = !m_mask && (m_cnt >= ((m_thr == 0) ? 1 : m_thr));
            m_tsc = (m_tsc + 1) % 65536;
        end
        e.cnt = m_cnt;
        e.irq = m_irq;
        e.ovr = m_ovr;
`ifdef PIT_IRQ_TIMESTAMP_EN
        e.ts  = m_ts[15:0];
`else
        e.ts  = 16'd0;
`endif
        sb.push_back(e);
    endtask

    // one clock: drive at negedge, predict, sample 1ns after the edge
    task automatic step(input logic r, t, a, mw, mv, tw, input int tv);
        exp_t e;
        @(negedge clk);
        reset = r; tick_in = t; ack = a; mask_wr = mw; mask_val = mv;
        thresh_wr = tw; thresh_val = tv[7:0];
        model(r, t, a, mw, mv, tw, tv);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pending_cnt", {24'd0, pending_cnt}, e.cnt);
        check("irq", {31'd0, irq}, {31'd0, e.irq});
        check("overrun", {31'd0, overrun}, {31'd0, e.ovr});
        check("ts_out", {16'd0, ts_out}, {16'd0, e.ts});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        step(0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_ack();
        step(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; tick_in = 0; ack = 0; mask_wr = 0; mask_val = 0;
        thresh_wr = 0; thresh_val = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // masked by default: tick does not raise irq
        tick();
        do_ack();
        // unmask, threshold 1: single tick raises irq, ack drops it
        step(0, 0, 0, 1, 0, 0, 0);
        tick();
        idle(2);
        do_ack();
        do_ack();

        // threshold 3, ticks spaced 5 apart
        step(0, 0, 0, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) begin tick(); idle(4); end
        // ack+tick with threshold >1 leaves irq low
        step(0, 1, 1, 0, 0, 0, 0);
        do_ack();

        // masked accumulation then unmask write
        step(0, 0, 0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) tick();
        step(0, 0, 0, 1, 0, 0, 0);
        // raising threshold above count drops irq, lowering restores it
        step(0, 0, 0, 0, 0, 1, 10);
        step(0, 1, 0, 0, 0, 1, 0);
        do_ack();

        // saturation and sticky overrun
        for (int i = 0; i < 258; i++) tick();
        idle(1);
        do_ack();

        // tick+ack at count 5, threshold 1
        for (int i = 0; i < 5; i++) tick();
        step(0, 1, 1, 0, 0, 0, 0);
        // mask write with tick and ack on the same edge
        step(0, 1, 1, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);

        // mid-operation reset with a tick on the reset edge
        tick();
        step(1, 1, 0, 0, 0, 0, 0);
        // timestamp scenario: ticks at cycles 20 and 30, ack, tick at 50
        idle(20);
        step(0, 1, 0, 1, 0, 0, 0);
        idle(9);
        tick();
        idle(8);
        do_ack();
        idle(10);
        tick();
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pit_irq_collector.md
# pit_irq_collector

Interrupt collector that sits directly downstream of the programmable interval timer. It consumes the timer's one-cycle `interrupting` pulses, counts pending events, and coalesces them behind a programmable threshold and a mask. It drives a level interrupt to the host, and the host clears it with a single-cycle acknowledge. Overflow of the pending count is flagged with a sticky overrun bit.

## Interface
Parameters:
- `CNT_W`, default 8: width of the pending-event counter and the threshold register.
- `TS_W`, default 16: width of the free-running timestamp counter. Used only with `PIT_IRQ_TIMESTAMP_EN`.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `tick_in`, input, 1: timer event pulse, one cycle per event; back-to-back pulses are legal.
- `mask_wr`, input, 1: write strobe; loads `mask_val` into the mask register.
- `mask_val`, input, 1: mask value; 1 = irq suppressed.
- `thresh_wr`, input, 1: write strobe; loads `thresh_val` into the threshold register.
- `thresh_val`, input, CNT_W: coalescing threshold.
- `ack`, input, 1: host acknowledge, one-cycle pulse.
- `irq`, output, 1: level interrupt to the host.
- `pending_cnt`, output, CNT_W: number of events not yet acknowledged.
- `overrun`, output, 1: sticky flag; an event arrived while `pending_cnt` was saturated.
- `ts_out`, output, TS_W: timestamp of the first event after the last ack.

## Operation
- Reset values:
  - `pending_cnt`=0, `overrun`=0, `irq`=0, `ts_out`=0.
  - mask=1 (masked), threshold=1, timestamp counter=0.
- Counter update, in priority order each cycle:
  - `ack` && `tick_in` → count=1.
  - `ack` → count=0.
  - `tick_in` && count==max (2^CNT_W−1) → count holds, `overrun` set.
  - `tick_in` → count+1.
  - No events lost except at saturation.
- `ack` also clears `overrun`. A same-cycle saturating tick cannot occur, because ack resets the count first.
- `ack` with count==0 has no effect other than clearing `overrun`.
- Effective threshold: `thresh_val`==0 is treated as 1.
- irq condition is `!mask && next_count >= eff_thresh`.
- State machine over next-state values:
  - IDLE: count==0.
  - PENDING: count>0 and (masked or count<thresh).
  - ASSERT: irq=1.
  - Transitions follow the counter and the irq condition. ASSERT → IDLE on ack with no tick. ASSERT → PENDING on ack+tick when eff_thresh>1.
- Mask or threshold writes take effect on the irq evaluated at the same edge. Unmasking with count ≥ thresh raises irq immediately. Raising the threshold above count drops irq.
- `mask_wr` and `thresh_wr` may coincide with `tick_in` and `ack`; all updates apply on the same edge.

## Timing
- All outputs are registered.
- `tick_in` sampled at edge N → `pending_cnt` and `irq` updated at edge N, visible in cycle N+1. Latency is 1 cycle.
- `ack` at edge N → `irq` low in cycle N+1, unless the same-cycle tick re-qualifies it.
- Reset mid-operation clears all state at the next edge. Ticks on the reset edge are discarded.
- Host handshake: the host must not hold `ack` high for more than one cycle. Each high cycle acts as a separate ack.

## Configuration
- `PIT_IRQ_TIMESTAMP_EN` defined:
  - A TS_W free-running counter increments every cycle from reset and wraps modulo 2^TS_W.
  - When a counted tick takes the count from 0 to 1, `ts_out` loads the counter value of that cycle. This includes ack+tick.
  - `ts_out` holds until the next such event.
- `PIT_IRQ_TIMESTAMP_EN` undefined:
  - The counter and capture logic are absent.
  - `ts_out` is tied to 0, and the port remains present.

## Test plan
- Reset, unmask, threshold=1, one tick → `pending_cnt`=1 and `irq`=1 one cycle later; ack → `pending_cnt`=0, `irq`=0.
- Threshold=3, three ticks spaced 5 cycles apart → `irq` stays 0 after ticks 1–2 and rises after tick 3; `pending_cnt`=3.
- Masked, 4 ticks → `irq`=0 and `pending_cnt`=4; unmask write → `irq`=1 on the next cycle.
- CNT_W=8, 256 consecutive ticks → `pending_cnt`=255 and `overrun`=1; ack → both 0.
- Tick and ack in the same cycle with count=5, threshold=1 → `pending_cnt`=1 and `irq` remains 1.
- With `PIT_IRQ_TIMESTAMP_EN`, first tick at cycle 20 after reset, second tick at 30 → `ts_out`=20. After ack, tick at 50 → `ts_out`=50. Without the macro, `ts_out`=0 throughout.
